// File: rtl/mips_multicycle_control_if.sv
// Control bundle between the multicycle sequencer (master) and the MIPS datapath / memory port (slave).
interface mips_multicycle_control_if #(
    parameter int unsigned ALU_OP_W = 6
);
    logic [5:0]          instr_op;
    logic [5:0]          instr_funct;
    logic                mem_ready;
    logic                branch_taken;
    logic                pc_wr;
    logic [1:0]          pc_src;
    logic                ir_wr;
    logic                mem_req;
    logic                mem_wr;
    logic                i_or_d;
    logic [ALU_OP_W-1:0] alu_op;
    logic [1:0]          alu_src_b;
    logic                sign_ext;
    logic                reg_wr;
    logic [1:0]          reg_dst;
    logic                mem_to_reg;
    logic                mdu_start;
    logic                halted;
    logic [1:0]          fault;

    modport master (
        input  instr_op, instr_funct, mem_ready, branch_taken,
        output pc_wr, pc_src, ir_wr, mem_req, mem_wr, i_or_d, alu_op, alu_src_b,
               sign_ext, reg_wr, reg_dst, mem_to_reg, mdu_start, halted, fault
    );

    modport slave (
        output instr_op, instr_funct, mem_ready, branch_taken,
        input  pc_wr, pc_src, ir_wr, mem_req, mem_wr, i_or_d, alu_op, alu_src_b,
               sign_ext, reg_wr, reg_dst, mem_to_reg, mdu_start, halted, fault
    );
endinterface

// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS sequencer: FETCH/DECODE/EXEC/MEM/WB over a shared ready-handshake memory port,
// multicycle MDU sequencing, and sticky halt on SYSCALL, illegal opcode or bus timeout.
module mips_multicycle_control #(
    parameter int unsigned MDU_LATENCY = 32,
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter int unsigned ALU_OP_W    = 6
) (
    input logic                       clk,
    input logic                       rst,
    mips_multicycle_control_if.master bus
);
    localparam int unsigned MDU_W = (MDU_LATENCY > 1) ? $clog2(MDU_LATENCY) : 1;
    localparam int unsigned TMO_W = $clog2(MEM_TIMEOUT + 1);

    localparam logic [ALU_OP_W-1:0] ALU_ADD  = ALU_OP_W'(0);
    localparam logic [ALU_OP_W-1:0] ALU_SUB  = ALU_OP_W'(1);
    localparam logic [ALU_OP_W-1:0] ALU_SLT  = ALU_OP_W'(2);
    localparam logic [ALU_OP_W-1:0] ALU_SLTU = ALU_OP_W'(3);
    localparam logic [ALU_OP_W-1:0] ALU_AND  = ALU_OP_W'(4);
    localparam logic [ALU_OP_W-1:0] ALU_NOR  = ALU_OP_W'(5);
    localparam logic [ALU_OP_W-1:0] ALU_XOR  = ALU_OP_W'(6);
    localparam logic [ALU_OP_W-1:0] ALU_LUI  = ALU_OP_W'(7);
    localparam logic [ALU_OP_W-1:0] ALU_OR   = ALU_OP_W'(8);
    localparam logic [ALU_OP_W-1:0] ALU_SLL  = ALU_OP_W'(9);
    localparam logic [ALU_OP_W-1:0] ALU_SRL  = ALU_OP_W'(10);
    localparam logic [ALU_OP_W-1:0] ALU_SRA  = ALU_OP_W'(11);
    localparam logic [ALU_OP_W-1:0] ALU_MFHI = ALU_OP_W'(12);
    localparam logic [ALU_OP_W-1:0] ALU_MFLO = ALU_OP_W'(13);
    localparam logic [ALU_OP_W-1:0] ALU_MTHI = ALU_OP_W'(14);
    localparam logic [ALU_OP_W-1:0] ALU_MTLO = ALU_OP_W'(15);

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_MDU_WAIT, S_HALT
    } state_t;

    typedef enum logic [3:0] {
        C_ALU_R, C_ALU_I, C_LOAD, C_STORE, C_BRANCH, C_J, C_JAL,
        C_JR, C_JALR, C_MDU, C_SYSCALL, C_ILLEGAL
    } class_t;

    state_t              state, state_nx;
    class_t              cls;
    logic [ALU_OP_W-1:0] dec_alu;
    logic                use_shamt;
    logic                zero_ext;
    logic                req;
    logic [MDU_W-1:0]    mdu_cnt, mdu_cnt_nx;
    logic [TMO_W-1:0]    tmo_cnt, tmo_cnt_nx;
    logic [1:0]          fault_q, fault_nx;

    // Instruction class and ALU operation straight from the IR fields
    always_comb begin
        cls       = C_ILLEGAL;
        dec_alu   = ALU_ADD;
        use_shamt = 1'b0;
        case (bus.instr_op)
            6'h00: begin
                cls = C_ALU_R;
                case (bus.instr_funct)
                    6'h00:                      begin dec_alu = ALU_SLL; use_shamt = 1'b1; end
                    6'h02:                      begin dec_alu = ALU_SRL; use_shamt = 1'b1; end
                    6'h03:                      begin dec_alu = ALU_SRA; use_shamt = 1'b1; end
                    6'h04:                      dec_alu = ALU_SLL;
                    6'h06:                      dec_alu = ALU_SRL;
                    6'h07:                      dec_alu = ALU_SRA;
                    6'h08:                      cls = C_JR;
                    6'h09:                      cls = C_JALR;
                    6'h0C:                      cls = C_SYSCALL;
                    6'h10:                      dec_alu = ALU_MFHI;
                    6'h11:                      dec_alu = ALU_MTHI;
                    6'h12:                      dec_alu = ALU_MFLO;
                    6'h13:                      dec_alu = ALU_MTLO;
                    6'h18, 6'h19, 6'h1A, 6'h1B: cls = C_MDU;
                    6'h20, 6'h21:               dec_alu = ALU_ADD;
                    6'h22, 6'h23:               dec_alu = ALU_SUB;
                    6'h24:                      dec_alu = ALU_AND;
                    6'h25:                      dec_alu = ALU_OR;
                    6'h26:                      dec_alu = ALU_XOR;
                    6'h27:                      dec_alu = ALU_NOR;
                    6'h2A:                      dec_alu = ALU_SLT;
                    6'h2B:                      dec_alu = ALU_SLTU;
                    default:                    cls = C_ILLEGAL;
                endcase
            end
            6'h02:                      cls = C_J;
            6'h03:                      cls = C_JAL;
            6'h04, 6'h05, 6'h06, 6'h07: begin cls = C_BRANCH; dec_alu = ALU_SUB; end
            6'h08, 6'h09:               cls = C_ALU_I;
            6'h0A:                      begin cls = C_ALU_I; dec_alu = ALU_SLT;  end
            6'h0B:                      begin cls = C_ALU_I; dec_alu = ALU_SLTU; end
            6'h0C:                      begin cls = C_ALU_I; dec_alu = ALU_AND;  end
            6'h0D:                      begin cls = C_ALU_I; dec_alu = ALU_OR;   end
            6'h0E:                      begin cls = C_ALU_I; dec_alu = ALU_XOR;  end
            6'h0F:                      begin cls = C_ALU_I; dec_alu = ALU_LUI;  end
            6'h20, 6'h21, 6'h23, 6'h24, 6'h25: cls = C_LOAD;
            6'h28, 6'h29, 6'h2B:        cls = C_STORE;
            default:                    cls = C_ILLEGAL;
        endcase
    end

    assign zero_ext = (bus.instr_op == 6'h0C) || (bus.instr_op == 6'h0D) || (bus.instr_op == 6'h0E);
    assign req      = (state == S_FETCH) || (state == S_MEM);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_FETCH;
            mdu_cnt <= '0;
            tmo_cnt <= '0;
            fault_q <= 2'b00;
        end else begin
            state   <= state_nx;
            mdu_cnt <= mdu_cnt_nx;
            tmo_cnt <= tmo_cnt_nx;
            fault_q <= fault_nx;
        end
    end

    // Next state and control outputs; everything reads zero while rst is held
    always_comb begin
        state_nx       = state;
        mdu_cnt_nx     = mdu_cnt;
        tmo_cnt_nx     = '0;
        fault_nx       = fault_q;
        bus.pc_wr      = 1'b0;
        bus.pc_src     = 2'b00;
        bus.ir_wr      = 1'b0;
        bus.mem_req    = 1'b0;
        bus.mem_wr     = 1'b0;
        bus.i_or_d     = 1'b0;
        bus.alu_op     = ALU_ADD;
        bus.alu_src_b  = 2'b00;
        bus.sign_ext   = 1'b0;
        bus.reg_wr     = 1'b0;
        bus.reg_dst    = 2'b00;
        bus.mem_to_reg = 1'b0;
        bus.mdu_start  = 1'b0;
        bus.halted     = 1'b0;
        bus.fault      = 2'b00;
        if (!rst) begin
            bus.fault    = fault_q;
            bus.sign_ext = (state != S_HALT) && !zero_ext;
            case (state)
                S_FETCH: begin
                    bus.mem_req   = 1'b1;
                    bus.alu_src_b = 2'b11;
                    if (bus.mem_ready) begin
                        bus.ir_wr = 1'b1;
                        bus.pc_wr = 1'b1;
                        state_nx  = S_DECODE;
                    end
                end
                S_DECODE: begin
                    bus.alu_src_b = 2'b01;
                    if (cls == C_ILLEGAL) begin
                        state_nx = S_HALT;
                        fault_nx = 2'b01;
                    end else if (cls == C_SYSCALL) begin
                        state_nx = S_HALT;
                        fault_nx = 2'b11;
                    end else begin
                        state_nx = S_EXEC;
                    end
                end
                S_EXEC: begin
                    bus.alu_op = dec_alu;
                    state_nx   = S_FETCH;
                    case (cls)
                        C_ALU_R:          begin bus.alu_src_b = use_shamt ? 2'b10 : 2'b00; state_nx = S_WB; end
                        C_ALU_I:          begin bus.alu_src_b = 2'b01; state_nx = S_WB;  end
                        C_LOAD, C_STORE:  begin bus.alu_src_b = 2'b01; state_nx = S_MEM; end
                        C_BRANCH:         begin bus.pc_wr = bus.branch_taken; bus.pc_src = 2'b01; end
                        C_J:              begin bus.pc_wr = 1'b1; bus.pc_src = 2'b10; end
                        C_JAL: begin
                            bus.pc_wr   = 1'b1;
                            bus.pc_src  = 2'b10;
                            bus.reg_wr  = 1'b1;
                            bus.reg_dst = 2'b10;
                        end
                        C_JR:             begin bus.pc_wr = 1'b1; bus.pc_src = 2'b11; end
                        C_JALR: begin
                            bus.pc_wr   = 1'b1;
                            bus.pc_src  = 2'b11;
                            bus.reg_wr  = 1'b1;
                            bus.reg_dst = 2'b01;
                        end
                        C_MDU: begin
                            bus.mdu_start = 1'b1;
                            mdu_cnt_nx    = MDU_W'(MDU_LATENCY - 1);
                            state_nx      = S_MDU_WAIT;
                        end
                        default: ;
                    endcase
                end
                S_MEM: begin
                    bus.mem_req = 1'b1;
                    bus.i_or_d  = 1'b1;
                    bus.mem_wr  = (cls == C_STORE);
                    if (bus.mem_ready) state_nx = (cls == C_STORE) ? S_FETCH : S_WB;
                end
                S_WB: begin
                    bus.reg_wr     = 1'b1;
                    bus.mem_to_reg = (cls == C_LOAD);
                    bus.reg_dst    = (bus.instr_op == 6'h00) ? 2'b01 : 2'b00;
                    state_nx       = S_FETCH;
                end
                S_MDU_WAIT: begin
                    if (mdu_cnt == '0) state_nx = S_FETCH;
                    else               mdu_cnt_nx = mdu_cnt - 1'b1;
                end
                S_HALT:  bus.halted = 1'b1;
                default: state_nx = S_FETCH;
            endcase
            // A ready arriving on the limit cycle completes the access instead of faulting
            if (req && !bus.mem_ready) begin
                if (tmo_cnt == TMO_W'(MEM_TIMEOUT - 1)) begin
                    state_nx = S_HALT;
                    fault_nx = 2'b10;
                end else begin
                    tmo_cnt_nx = tmo_cnt + 1'b1;
                end
            end
        end
    end
endmodule
